// File: rtl/oled_refresh_scheduler_pkg.sv
// Shared definitions for the OLED refresh scheduler: FSM state encoding,
// line count and the width of a line index.
package oled_sched_pkg;

  localparam int NUM_LINES = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_REFRESH = 2'd2,
    ST_HOLD    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/oled_refresh_scheduler_if.sv
// Line-writer port: one write of a display line per handshake, with an
// optional commit that asks the scheduler for a refresh. ready is the grant.
interface oled_refresh_scheduler_if #(
  parameter int DATA_W = 32
);

  logic                             valid;
  logic [oled_sched_pkg::IDX_W-1:0] idx;
  logic [DATA_W-1:0]                data;
  logic                             commit;
  logic                             ready;

  modport master (output valid, output idx, output data, output commit, input ready);
  modport slave  (input valid, input idx, input data, input commit, output ready);

endinterface

// File: rtl/oled_refresh_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter. A lone requester always wins; under
// contention the requester named by the pointer wins and the pointer flips.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_r;

  // Combinational grant: at most one bit set.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the other requester only after a contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (req == 2'b11) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/oled_refresh_scheduler.sv
// OLED refresh scheduler: two writers share four shadow line registers, a
// commit marks the frame dirty, and the FSM latches the shadows into the
// display lines and drives PmodOLEDCtrl's EN/FIN handshake, followed by a
// holdoff so refreshes are rate-limited. Display lines never change while
// a refresh is in flight.
module oled_refresh_scheduler
  import oled_sched_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int HOLDOFF     = 100000,
  parameter int FIN_TIMEOUT = 2000000
) (
  input  logic                      CLK,
  input  logic                      RST,
  oled_refresh_scheduler_if.slave   s0,
  oled_refresh_scheduler_if.slave   s1,
  output logic                      oled_en,
  input  logic                      oled_fin,
  output logic [DATA_W-1:0]         line0,
  output logic [DATA_W-1:0]         line1,
  output logic [DATA_W-1:0]         line2,
  output logic [DATA_W-1:0]         line3,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
  localparam logic [CNT_W-1:0] TO_LAST   = (FIN_TIMEOUT > 0) ? CNT_W'(FIN_TIMEOUT - 1) : '0;
  localparam bit               TO_EN     = (FIN_TIMEOUT > 0);

  // Arbitration and the selected write
  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_commit_s;

  // Buffers and control state
  logic [DATA_W-1:0] shadow_r [NUM_LINES];
  logic [DATA_W-1:0] line_r   [NUM_LINES];
  logic              dirty_r;
  logic              fin_q_r;
  logic              fin_rise_s;
  logic [CNT_W-1:0]  cnt_r;
  sched_state_t      state_r;
  sched_state_t      next_state_s;
  logic              to_hit_s;
  logic              oled_en_r;
  logic              busy_r;
  logic              err_r;

  assign req_s = {s1.valid, s0.valid};

  rr_arbiter2 u_arb (
    .clk   (CLK),
    .rst_n (RST),
    .req   (req_s),
    .grant (grant_s)
  );

  assign s0.ready = grant_s[0];
  assign s1.ready = grant_s[1];

  // Route the granted writer onto a single write port; commit only counts when granted.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_idx_s    = '0;
    wr_data_s   = '0;
    wr_commit_s = 1'b0;
    if (grant_s[1]) begin
      wr_en_s     = 1'b1;
      wr_idx_s    = s1.idx;
      wr_data_s   = s1.data;
      wr_commit_s = s1.commit;
    end else if (grant_s[0]) begin
      wr_en_s     = 1'b1;
      wr_idx_s    = s0.idx;
      wr_data_s   = s0.data;
      wr_commit_s = s0.commit;
    end else begin
      wr_en_s     = 1'b0;
      wr_commit_s = 1'b0;
    end
  end

  // Shadow lines accept a granted write in every state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        shadow_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      shadow_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Display lines load only in LATCH, with a same-cycle write bypassing the shadow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        line_r[i] <= '0;
      end
    end else if (state_r == ST_LATCH) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        line_r[i] <= (wr_en_s && (wr_idx_s == IDX_W'(i))) ? wr_data_s : shadow_r[i];
      end
    end
  end

  // Dirty flag: a granted commit sets it and beats the clear in LATCH.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dirty_r <= 1'b0;
    end else if (wr_commit_s) begin
      dirty_r <= 1'b1;
    end else if (state_r == ST_LATCH) begin
      dirty_r <= 1'b0;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Delayed FIN for rising-edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fin_q_r <= 1'b0;
    end else begin
      fin_q_r <= oled_fin;
    end
  end

  assign fin_rise_s = oled_fin & ~fin_q_r;

  // Cycles spent in the current state; restarts on every transition and saturates.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= '0;
    end else if (next_state_s != state_r) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state and timeout detection.
  always_comb begin
    next_state_s = state_r;
    to_hit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dirty_r) begin
          next_state_s = ST_LATCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        next_state_s = ST_REFRESH;
      end
      ST_REFRESH: begin
        if (fin_rise_s) begin
          next_state_s = ST_HOLD;
        end else if (TO_EN && (cnt_r >= TO_LAST)) begin
          next_state_s = ST_HOLD;
          to_hit_s     = 1'b1;
        end else begin
          next_state_s = ST_REFRESH;
        end
      end
      ST_HOLD: begin
        if (cnt_r >= HOLD_LAST) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Registered handshake and status outputs, aligned with the state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      oled_en_r <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      oled_en_r <= (next_state_s == ST_REFRESH);
      busy_r    <= (next_state_s != ST_IDLE);
      err_r     <= err_r | to_hit_s;
    end
  end

  assign oled_en     = oled_en_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;
  assign line0       = line_r[0];
  assign line1       = line_r[1];
  assign line2       = line_r[2];
  assign line3       = line_r[3];

endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// Directed bench for oled_refresh_scheduler with a short holdoff and FIN
// timeout; expected values are worked out by hand from the cycle timing.
module tb_oled_refresh_scheduler;

  localparam int DATA_W      = 32;
  localparam int HOLDOFF     = 10;
  localparam int FIN_TIMEOUT = 50;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              oled_en;
  logic              oled_fin = 1'b0;
  logic [DATA_W-1:0] line0, line1, line2, line3;
  logic              busy;
  logic              err_timeout;

  int vectors     = 0;
  int miscompares = 0;

  oled_refresh_scheduler_if #(.DATA_W(DATA_W)) w0 ();
  oled_refresh_scheduler_if #(.DATA_W(DATA_W)) w1 ();

  oled_refresh_scheduler #(
    .DATA_W      (DATA_W),
    .HOLDOFF     (HOLDOFF),
    .FIN_TIMEOUT (FIN_TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .s0          (w0),
    .s1          (w1),
    .oled_en     (oled_en),
    .oled_fin    (oled_fin),
    .line0       (line0),
    .line1       (line1),
    .line2       (line2),
    .line3       (line3),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    w0.valid = 1'b0; w0.idx = 2'd0; w0.data = 32'h0; w0.commit = 1'b0;
    w1.valid = 1'b0; w1.idx = 2'd0; w1.data = 32'h0; w1.commit = 1'b0;
  endtask

  // One uncontended write through writer sel; returns one cycle after the grant edge.
  task automatic put(input logic sel, input logic [1:0] idx, input logic [31:0] data,
                     input logic commit);
    if (sel) begin
      w1.valid = 1'b1; w1.idx = idx; w1.data = data; w1.commit = commit;
      #1;
      chk("ready_s1", {31'd0, w1.ready}, 32'd1);
    end else begin
      w0.valid = 1'b1; w0.idx = idx; w0.data = data; w0.commit = commit;
      #1;
      chk("ready_s0", {31'd0, w0.ready}, 32'd1);
    end
    @(posedge CLK);
    #1;
    quiet();
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (oled_en !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic wait_en_low(output int n);
    n = 0;
    while (oled_en !== 1'b0 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
  endtask

  // Pulse FIN, expect EN to drop, then expect exactly HOLDOFF cycles of HOLD.
  task automatic finish_refresh();
    int n;
    oled_fin = 1'b1;
    step();
    chk("en_fall", {31'd0, oled_en}, 32'd0);
    oled_fin = 1'b0;
    wait_idle(n);
    chk("holdoff_len", n, HOLDOFF);
  endtask

  logic [1:0]  i0 [3] = '{2'd0, 2'd1, 2'd2};
  logic [31:0] d0 [3] = '{32'h11, 32'h12, 32'h13};
  logic [31:0] d1 [3] = '{32'h21, 32'h22, 32'h23};
  logic        c1 [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    int p0;
    int p1;
    logic g0, g1, seen;

    quiet();
    #12;
    chk("rst_en", {31'd0, oled_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_line0", line0, 32'h0);
    chk("rst_line3", line3, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    step();

    // Single writer, commit on the last line.
    put(1'b0, 2'd0, 32'hA, 1'b0);
    put(1'b0, 2'd1, 32'hB, 1'b0);
    put(1'b0, 2'd2, 32'hC, 1'b0);
    put(1'b0, 2'd3, 32'hD, 1'b1);
    chk("t1_en_early", {31'd0, oled_en}, 32'd0);
    wait_en(n);
    chk("t1_latency", n, 2);
    chk("t1_line0", line0, 32'hA);
    chk("t1_line1", line1, 32'hB);
    chk("t1_line2", line2, 32'hC);
    chk("t1_line3", line3, 32'hD);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    chk("t1_en_held", {31'd0, oled_en}, 32'd1);
    finish_refresh();

    // Contention: both writers hold requests until granted.
    p0 = 0;
    p1 = 0;
    for (int c = 0; c < 6; c++) begin
      w0.valid = (p0 < 3); w0.idx = i0[(p0 > 2) ? 2 : p0]; w0.data = d0[(p0 > 2) ? 2 : p0];
      w0.commit = 1'b0;
      w1.valid = (p1 < 3); w1.idx = 2'd3; w1.data = d1[(p1 > 2) ? 2 : p1];
      w1.commit = c1[(p1 > 2) ? 2 : p1];
      #1;
      chk("rr_s0", {31'd0, w0.ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_s1", {31'd0, w1.ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
      g0 = w0.ready;
      g1 = w1.ready;
      @(posedge CLK);
      #1;
      if (g0) p0++;
      if (g1) p1++;
    end
    quiet();
    chk("rr_p0", p0, 3);
    chk("rr_p1", p1, 3);
    wait_en(n);
    chk("t2_latency", n, 2);
    chk("t2_line0", line0, 32'h11);
    chk("t2_line1", line1, 32'h12);
    chk("t2_line2", line2, 32'h13);
    chk("t2_line3", line3, 32'h23);
    finish_refresh();

    // Mid-refresh write gets one follow-up refresh; lines frozen meanwhile.
    put(1'b0, 2'd2, 32'h77, 1'b1);
    wait_en(n);
    chk("t3_latency", n, 2);
    chk("t3_line2_a", line2, 32'h77);
    put(1'b1, 2'd2, 32'h55, 1'b1);
    step();
    chk("t3_line2_frozen", line2, 32'h77);
    oled_fin = 1'b1;
    step();
    chk("t3_line2_fin", line2, 32'h77);
    oled_fin = 1'b0;
    wait_idle(n);
    chk("t3_holdoff", n, HOLDOFF);
    wait_en(n);
    chk("t3_followup", n, 2);
    chk("t3_line2_b", line2, 32'h55);
    finish_refresh();
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      seen = seen | oled_en | busy;
    end
    chk("t3_no_third", {31'd0, seen}, 32'd0);

    // Commit granted in the LATCH cycle: data included, second refresh follows.
    put(1'b0, 2'd0, 32'h99, 1'b1);
    step();
    w1.valid = 1'b1; w1.idx = 2'd1; w1.data = 32'hAA; w1.commit = 1'b1;
    #1;
    chk("t4_ready_latch", {31'd0, w1.ready}, 32'd1);
    @(posedge CLK);
    #1;
    quiet();
    chk("t4_en", {31'd0, oled_en}, 32'd1);
    chk("t4_line0", line0, 32'h99);
    chk("t4_line1", line1, 32'hAA);
    finish_refresh();
    wait_en(n);
    chk("t4_second", n, 2);
    chk("t4_line1_b", line1, 32'hAA);
    finish_refresh();

    // FIN stuck low: timeout after FIN_TIMEOUT cycles in REFRESH.
    put(1'b1, 2'd3, 32'hEE, 1'b1);
    wait_en(n);
    chk("t5_latency", n, 2);
    wait_en_low(n);
    chk("t5_timeout_len", n, FIN_TIMEOUT);
    chk("t5_err", {31'd0, err_timeout}, 32'd1);
    chk("t5_busy_hold", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("t5_holdoff", n, HOLDOFF);
    chk("t5_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset during REFRESH with a commit pending.
    put(1'b0, 2'd0, 32'h33, 1'b1);
    wait_en(n);
    chk("t6_latency", n, 2);
    put(1'b1, 2'd1, 32'h44, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_en_async", {31'd0, oled_en}, 32'd0);
    chk("t6_busy_async", {31'd0, busy}, 32'd0);
    chk("t6_line0_async", line0, 32'h0);
    chk("t6_err_async", {31'd0, err_timeout}, 32'd0);
    step();
    RST = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen = seen | oled_en | busy;
    end
    chk("t6_no_refresh", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
